// File: rtl/count_capture_fifo_negedge_async_resetn.sv
// -----------------------------------------------------------------------------
// count_capture_fifo_negedge_async_resetn
//
// Timestamps events: each rising edge of event_i pushes the live count_i value
// into a small first-word fall-through FIFO. A consumer drains it with a
// valid/ready handshake. All state updates happen on the falling edge of
// clock0_i, the same domain as the upstream counter.
//
// Optional feature: define CAPTURE_DROP_COUNT_EN to add drop_count_o, a
// saturating 8-bit count of dropped events cleared by clear_ovf_i.
//
// Ports
//   clock0_i      clock, state updates on negedge
//   reset_ni      asynchronous active-low reset
//   count_i       live counter value to be captured
//   event_i       event strobe; rising edge requests a capture
//   out_ready_i   consumer accepts out_data_o this cycle
//   clear_ovf_i   clears the sticky overflow flag (and drop_count_o)
//   out_valid_o   FIFO non-empty
//   out_data_o    oldest captured timestamp
//   fifo_level_o  number of entries held, 0..DEPTH
//   overflow_o    sticky flag: an event was dropped because the FIFO was full
//   drop_count_o  (CAPTURE_DROP_COUNT_EN only) saturating dropped-event count
// -----------------------------------------------------------------------------
module count_capture_fifo_negedge_async_resetn #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clock0_i,
    input  logic             reset_ni,
    input  logic [WIDTH-1:0] count_i,
    input  logic             event_i,
    input  logic             out_ready_i,
    input  logic             clear_ovf_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic [PTR_W:0]   fifo_level_o,
    output logic             overflow_o
`ifdef CAPTURE_DROP_COUNT_EN
    ,
    output logic [7:0]       drop_count_o
`endif
);

    localparam logic [PTR_W:0]   FullLevel = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   LevelOne  = 1;
    localparam logic [PTR_W-1:0] PtrOne    = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             event_prev_q;
    logic             overflow_q, overflow_d;

    logic cap, full, pop, push, drop;

    // event_prev_q resets high so an event held high across reset release
    // does not look like a rising edge.
    assign cap  = event_i & ~event_prev_q;
    assign full = (level_q == FullLevel);
    assign pop  = (level_q != '0) & out_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (push) begin
            mem_d[wr_ptr_q] = count_i;
            wr_ptr_d        = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LevelOne;
            2'b01:   level_d = level_q - LevelOne;
            default: level_d = level_q;
        endcase

        // A new drop beats a simultaneous clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(negedge clock0_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            event_prev_q <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            event_prev_q <= event_i;
            overflow_q   <= overflow_d;
        end
    end

`ifdef CAPTURE_DROP_COUNT_EN
    logic [7:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop) begin
            // Clear and drop together leave exactly this one drop counted.
            if (clear_ovf_i) begin
                drop_count_d = 8'd1;
            end else if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end else if (clear_ovf_i) begin
            drop_count_d = 8'd0;
        end
    end

    always_ff @(negedge clock0_i or negedge reset_ni) begin
        if (!reset_ni) begin
            drop_count_q <= 8'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count_o = drop_count_q;
`endif

    // Outputs come straight from registers; no combinational input path.
    assign out_valid_o  = (level_q != '0);
    assign out_data_o   = mem_q[rd_ptr_q];
    assign fifo_level_o = level_q;
    assign overflow_o   = overflow_q;

endmodule
